// File: rtl/hazard_ctrl_unit_pkg.sv
// Package: hazard_ctrl_unit_pkg
// Purpose: shared definitions for the pipeline hazard control unit.
//   - state_t    : hazard FSM encodings (ST_RUN, ST_MEM_WAIT)
//   - ctrl_t     : bundle of all pipeline-register control outputs
//   - CTRL_NOP   : every enable low, no flush/bubble (reset value)
//   - CTRL_PASS  : free-running pipeline, every enable high
//   - load_use() : load-use hazard detection between EX and ID
package hazard_ctrl_unit_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam ctrl_t CTRL_PASS = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_write:   1'b1,
    id_ex_bubble:  1'b0,
    ex_mem_write:  1'b1,
    mem_wb_bubble: 1'b0
  };

  // $zero is hard-wired, so a load targeting it can never create a hazard.
  function automatic logic load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Module: sat_counter
// Purpose: saturating up-counter used for the performance statistics.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      asynchronous active-high reset, clears count
//   inc   in  1      count this edge
//   count out CNT_W  current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Module: hazard_ctrl_unit
// Purpose: stall/flush control for the 5-stage pipeline. Resolves data-memory
//   waits (whole-pipe freeze), load-use hazards (one bubble) and ID-stage
//   redirects (IF/ID flush), and counts stall and flush cycles.
// Ports:
//   clk, rst                   clock / asynchronous active-high reset
//   ID_Rs, ID_Rt, ID_UsesRt    source operands of the instruction in ID
//   EX_MemRead, EX_Rt          load in EX and its destination
//   MEM_MemAccess              load/store entering its MEM access
//   ID_Redirect                branch taken / jump resolved in ID
//   PCWrite .. MEM_WB_Bubble   pipeline register controls (combinational)
//   StallCount, FlushCount     saturating performance counters
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             MEM_MemAccess,
  input  logic             ID_Redirect,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // Wait counter only needs to hold MEM_LAT-2.
  localparam int WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam bit HAS_WAIT = (MEM_LAT > 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              mem_start;
  logic              mem_freeze;
  logic              lu_hazard;
  ctrl_t             ctrl;

  assign mem_start  = HAS_WAIT && MEM_MemAccess && (state == ST_RUN);
  assign mem_freeze = mem_start || (state == ST_MEM_WAIT);
  assign lu_hazard  = load_use(EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt);

  // The first access cycle already freezes (in RUN); MEM_WAIT then covers
  // wcnt+1 further cycles so the access spans MEM_LAT cycles in total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      wcnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_start) begin
            state <= ST_MEM_WAIT;
            wcnt  <= WCNT_LOAD;
          end
        end
        ST_MEM_WAIT: begin
          if (wcnt == '0) begin
            state <= ST_RUN;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Redirects are dropped under a freeze or load-use stall; ID keeps the
  // branch and re-presents it once it can actually advance.
  always_comb begin
    ctrl = CTRL_PASS;
    if (rst) begin
      ctrl = CTRL_NOP;
    end else if (mem_freeze) begin
      ctrl               = CTRL_NOP;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (lu_hazard) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end else if (ID_Redirect) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign PCWrite       = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Write   = ctrl.id_ex_write;
  assign ID_EX_Bubble  = ctrl.id_ex_bubble;
  assign EX_MEM_Write  = ctrl.ex_mem_write;
  assign MEM_WB_Bubble = ctrl.mem_wb_bubble;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_write),
    .count (StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.if_id_flush),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Two instances share all inputs:
//   u_dut  : MEM_LAT=4, CNT_W=32 (main behaviour)
//   u_sat  : MEM_LAT=1, CNT_W=4  (no-wait-state memory, counter saturation)
// Control outputs are packed as {PCWrite, IF_ID_Write, IF_ID_Flush,
// ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}.
module tb_hazard_ctrl_unit;

  localparam logic [6:0] C_OFF  = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_RED  = 7'b1111010;
  localparam logic [6:0] C_MEMW = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, mem_access, id_redirect;

  logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_w, s_memwb_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .MEM_MemAccess(mem_access),
    .ID_Redirect(id_redirect), .PCWrite(pc_w), .IF_ID_Write(ifid_w),
    .IF_ID_Flush(ifid_f), .ID_EX_Write(idex_w), .ID_EX_Bubble(idex_b),
    .EX_MEM_Write(exmem_w), .MEM_WB_Bubble(memwb_b),
    .StallCount(stall_cnt), .FlushCount(flush_cnt)
  );

  hazard_ctrl_unit #(.MEM_LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .MEM_MemAccess(mem_access),
    .ID_Redirect(id_redirect), .PCWrite(s_pc_w), .IF_ID_Write(s_ifid_w),
    .IF_ID_Flush(s_ifid_f), .ID_EX_Write(s_idex_w), .ID_EX_Bubble(s_idex_b),
    .EX_MEM_Write(s_exmem_w), .MEM_WB_Bubble(s_memwb_b),
    .StallCount(s_stall_cnt), .FlushCount(s_flush_cnt)
  );

  wire [6:0] ctrl   = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b};
  wire [6:0] s_ctrl = {s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_w, s_memwb_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 3 units later, well before the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; mem_access = 1'b0; id_redirect = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  initial begin
    // 1: reset holds everything low, even with a hazard pattern applied
    rst = 1'b1;
    clear_inputs();
    next();
    set_load_use();
    id_redirect = 1'b1;
    next();
    settle();
    chk("rst_ctrl", 32'(ctrl), 32'(C_OFF));
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    next();
    rst = 1'b0;
    clear_inputs();
    settle();
    chk("release_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("release_stall", stall_cnt, 32'd0);

    // 2: load-use on rs gives a single bubble
    next();
    set_load_use();
    settle();
    chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
    next();
    clear_inputs();
    settle();
    chk("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("lu_stall", stall_cnt, 32'd1);

    // 3: $zero and unused rt never stall; used rt does
    next();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    settle();
    chk("zero_reg_ctrl", 32'(ctrl), 32'(C_RUN));
    next();
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    settle();
    chk("rt_unused_ctrl", 32'(ctrl), 32'(C_RUN));
    next();
    id_uses_rt = 1'b1;
    settle();
    chk("rt_used_ctrl", 32'(ctrl), 32'(C_LU));
    next();
    clear_inputs();
    settle();
    chk("rt_stall", stall_cnt, 32'd2);

    // 4: redirect without hazard flushes IF/ID for one cycle
    next();
    id_redirect = 1'b1;
    settle();
    chk("redir_ctrl", 32'(ctrl), 32'(C_RED));
    next();
    clear_inputs();
    settle();
    chk("redir_after", 32'(ctrl), 32'(C_RUN));
    chk("redir_flush", flush_cnt, 32'd1);

    // 5: memory access with MEM_LAT=4: access cycle plus three MEM_WAIT
    //    cycles frozen; load-use and redirect pending throughout
    next();
    mem_access = 1'b1;
    set_load_use();
    id_redirect = 1'b1;
    settle();
    chk("mem_start", 32'(ctrl), 32'(C_MEMW));
    chk("nowait_lu", 32'(s_ctrl), 32'(C_LU));
    for (int i = 0; i < 3; i++) begin
      next();
      mem_access = 1'b0;
      settle();
      chk($sformatf("mem_wait%0d", i), 32'(ctrl), 32'(C_MEMW));
    end
    next();
    settle();
    chk("mem_end_lu", 32'(ctrl), 32'(C_LU));
    next();
    clear_inputs();
    settle();
    chk("mem_stall", stall_cnt, 32'd7);
    chk("mem_flush", flush_cnt, 32'd1);

    // reset in the middle of MEM_WAIT leaves no residual freeze
    next();
    mem_access = 1'b1;
    settle();
    chk("mid_start", 32'(ctrl), 32'(C_MEMW));
    next();
    mem_access = 1'b0;
    settle();
    chk("mid_wait", 32'(ctrl), 32'(C_MEMW));
    next();
    rst = 1'b1;
    settle();
    chk("mid_rst_ctrl", 32'(ctrl), 32'(C_OFF));
    chk("mid_rst_stall", stall_cnt, 32'd0);
    next();
    rst = 1'b0;
    settle();
    chk("mid_release", 32'(ctrl), 32'(C_RUN));
    next();
    settle();
    chk("mid_release2", 32'(ctrl), 32'(C_RUN));
    chk("mid_stall", stall_cnt, 32'd0);

    // 6: 20 stalled cycles: 32-bit counter reaches 20, 4-bit sticks at 15
    next();
    set_load_use();
    repeat (19) next();
    next();
    clear_inputs();
    settle();
    chk("sat_main", stall_cnt, 32'd20);
    chk("sat_4bit", 32'(s_stall_cnt), 32'd15);
    next();
    settle();
    chk("sat_hold", 32'(s_stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
